sha256_header_ctrl: RTL and testbench
=====================================

Name: sha256_header_ctrl

Overview:
- Sequencer that drives one sha256 core to hash an 80-byte (640-bit) mining header.
- Runs block 0 (header[639:128] from the standard IV) and block 1 (header[127:0] plus padding from the midstate). Optionally runs block 2, a second SHA-256 over the 256-bit digest (SHA256d).
- Caches the block-0 midstate and skips block 0 when the next header has the same first 64 bytes.
- Sits between the job/nonce logic and the sha256 core instance.

Parameters:
DOUBLE_HASH, 1, 1 = append block 2 (SHA256d); 0 = single SHA-256 of the header
MIDSTATE_CACHE, 1, 1 = enable the block-0 midstate cache; 0 = always run block 0
TIMEOUT_CYCLES, 255, maximum cycles from core_enable to core_hash_done before abort (counter width = clog2(TIMEOUT_CYCLES+1))

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  request a hash; accepted only in IDLE
header  input  640  header, byte 0 at [639:632]; sampled on the accept cycle
cache_flush  input  1  clears the midstate cache valid bit (any state)
busy  output  1  high from the accept cycle+1 until the done cycle inclusive
done  output  1  one-cycle completion pulse
error  output  1  high with done when the job aborted on timeout
digest  output  256  result {H0..H7} as the core emits it, no byte swap; held until the next accept
core_n_rst  output  1  core reset = ~(rst | abort), combinational
core_enable  output  1  one-cycle start pulse to the core
core_data  output  512  core message block; stable for the whole block
core_hash  output  256  core chaining value; stable for the whole block
core_result  input  256  core hash output
core_hash_done  input  1  core completion pulse (1 cycle)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, error=0, digest=0, core_enable=0, core_data=0, core_hash=0, cache valid=0, timeout counter=0.
- States: IDLE, B0, B1, B2, FIN, ABORT.
- IDLE + start: latch the header. Next state is B1 if MIDSTATE_CACHE && valid && tag==header[639:128]; otherwise B0. A start outside IDLE is ignored.
- Every Bx state:
  - core_enable=1 on the first cycle only; core_data/core_hash are registered and constant throughout.
  - Wait for core_hash_done, then capture core_result.
  - Next state: B0→B1; B1→B2 if DOUBLE_HASH, else FIN; B2→FIN.
- Block contents (IV = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19):
  - B0: data=header[639:128], hash=IV. On completion, store midstate and tag=header[639:128], and set valid=1.
  - B1: data={header[127:0],32'h80000000,288'h0,64'h280}, hash=midstate (freshly computed or cached).
  - B2: data={B1 result,32'h80000000,160'h0,64'h100}, hash=IV.
- FIN: done=1 for one cycle; digest = last captured result; next state IDLE.
- Latency, start accepted at cycle S. The core returns done 67 cycles after core_enable, but the controller must wait on the pulse, not count cycles. Block entries are S+1, S+69, S+137.
  - done at S+205: miss, double.
  - done at S+137: miss, single; or hit, double.
  - done at S+69: hit, single.
- Timeout: counter resets on each core_enable. If it reaches TIMEOUT_CYCLES without core_hash_done, go to ABORT.
  - ABORT (1 cycle): abort=1 (core_n_rst=0), valid=0, done=1, error=1, digest unchanged; next state IDLE.
- cache_flush concurrent with B0 completion: the flush wins (valid=0), but the current job still uses the new midstate.
- rst mid-job: immediate return to IDLE; no done pulse; cache invalidated; core reset via core_n_rst.
- A core_hash_done pulse in IDLE/FIN is ignored.

Test Plan:
- header=640'h0, cache empty, DOUBLE_HASH=1 → B0, B1, B2 run. B1 core_data={128'h0,32'h80000000,288'h0,64'h280}. done at S+205. digest matches the software SHA256d of 80 zero bytes.
- Repeat the same header with nonce bytes header[31:0]=32'h1 → cache hit: no B0 core_enable, first core_enable at S+1, done at S+137, digest matches the model.
- cache_flush pulsed between jobs, same header → B0 runs again, done at S+205.
- Core model withholds core_hash_done → after TIMEOUT_CYCLES (255) from enable: core_n_rst low 1 cycle, done=1, error=1; next job misses the cache.
- rst asserted at S+100 → next cycle state=IDLE, busy=0, no done; a fresh start then completes normally.
- start asserted while busy, and the core's 1-cycle done compared against the core_enable spacing → the extra start is ignored, and core_enable is never high when core_hash_done is high.

Source files
------------

// File: rtl/sha256_header_ctrl_if.sv
// Bus between the header sequencer and a single sha256 compression core.
// The sequencer is the master; the core (or a core model) is the slave.
interface sha256_header_ctrl_if;
    logic         core_n_rst;
    logic         core_enable;
    logic [511:0] core_data;
    logic [255:0] core_hash;
    logic [255:0] core_result;
    logic         core_hash_done;

    modport master (
        output core_n_rst,
        output core_enable,
        output core_data,
        output core_hash,
        input  core_result,
        input  core_hash_done
    );

    modport slave (
        input  core_n_rst,
        input  core_enable,
        input  core_data,
        input  core_hash,
        output core_result,
        output core_hash_done
    );
endinterface

// File: rtl/sha256_header_ctrl.sv
// Sequences one sha256 core through the blocks of an 80-byte mining header
// (optionally SHA256d), caching the block-0 midstate between jobs.
module sha256_header_ctrl #(
    parameter int DOUBLE_HASH    = 1,
    parameter int MIDSTATE_CACHE = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [639:0]          header,
    input  logic                  cache_flush,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [255:0]          digest,
    sha256_header_ctrl_if.master  core
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        FIN,
        ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [639:0]  header_q, header_d;
    logic [511:0]  tag_q, tag_d;
    logic [255:0]  midstate_q, midstate_d;
    logic          valid_q, valid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          enable_q, enable_d;
    logic [511:0]  data_q, data_d;
    logic [255:0]  hash_q, hash_d;
    logic [255:0]  digest_q, digest_d;
    logic          cache_hit;

    // Second block: header tail, 0x80 terminator, 640-bit message length.
    function automatic logic [511:0] block1_data(input logic [127:0] tail);
        return {tail, 32'h80000000, 288'h0, 64'h280};
    endfunction

    // Outer hash of SHA256d: 256-bit digest, terminator, 256-bit length.
    function automatic logic [511:0] block2_data(input logic [255:0] inner);
        return {inner, 32'h80000000, 160'h0, 64'h100};
    endfunction

    assign cache_hit = (MIDSTATE_CACHE != 0) && valid_q && (tag_q == header[639:128]);

    always_comb begin
        state_d    = state_q;
        header_d   = header_q;
        tag_d      = tag_q;
        midstate_d = midstate_q;
        valid_d    = valid_q;
        timer_d    = timer_q;
        enable_d   = 1'b0;
        data_d     = data_q;
        hash_d     = hash_q;
        digest_d   = digest_q;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (start) begin
                    header_d = header;
                    enable_d = 1'b1;
                    if (cache_hit) begin
                        state_d = B1;
                        data_d  = block1_data(header[127:0]);
                        hash_d  = midstate_q;
                    end else begin
                        state_d = B0;
                        data_d  = header[639:128];
                        hash_d  = SHA_IV;
                    end
                end
            end

            B0, B1, B2: begin
                if (core.core_hash_done) begin
                    timer_d = '0;
                    case (state_q)
                        B0: begin
                            midstate_d = core.core_result;
                            tag_d      = header_q[639:128];
                            valid_d    = 1'b1;
                            state_d    = B1;
                            enable_d   = 1'b1;
                            data_d     = block1_data(header_q[127:0]);
                            hash_d     = core.core_result;
                        end
                        B1: begin
                            if (DOUBLE_HASH != 0) begin
                                state_d  = B2;
                                enable_d = 1'b1;
                                data_d   = block2_data(core.core_result);
                                hash_d   = SHA_IV;
                            end else begin
                                state_d  = FIN;
                                digest_d = core.core_result;
                            end
                        end
                        default: begin
                            state_d  = FIN;
                            digest_d = core.core_result;
                        end
                    endcase
                end else if (timer_q == TIMEOUT_LIMIT) begin
                    state_d = ABORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            ABORT: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush always wins, even against a midstate being stored this cycle.
        if (cache_flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            header_q   <= '0;
            tag_q      <= '0;
            midstate_q <= '0;
            valid_q    <= 1'b0;
            timer_q    <= '0;
            enable_q   <= 1'b0;
            data_q     <= '0;
            hash_q     <= '0;
            digest_q   <= '0;
        end else begin
            state_q    <= state_d;
            header_q   <= header_d;
            tag_q      <= tag_d;
            midstate_q <= midstate_d;
            valid_q    <= valid_d;
            timer_q    <= timer_d;
            enable_q   <= enable_d;
            data_q     <= data_d;
            hash_q     <= hash_d;
            digest_q   <= digest_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == FIN) || (state_q == ABORT);
    assign error  = (state_q == ABORT);
    assign digest = digest_q;

    assign core.core_n_rst  = ~(rst | (state_q == ABORT));
    assign core.core_enable = enable_q;
    assign core.core_data   = data_q;
    assign core.core_hash   = hash_q;

endmodule

// File: tb/tb_sha256_header_ctrl.sv
// Directed bench for sha256_header_ctrl with a behavioural SHA-256 core model
// that answers 67 cycles after each core_enable.
module tb_sha256_header_ctrl;

    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [639:0] header;
    logic         cache_flush;
    logic         busy;
    logic         done;
    logic         error;
    logic [255:0] digest;

    sha256_header_ctrl_if core_bus ();

    sha256_header_ctrl #(
        .DOUBLE_HASH    (1),
        .MIDSTATE_CACHE (1),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .header      (header),
        .cache_flush (cache_flush),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .digest      (digest),
        .core        (core_bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = h_in;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
                h_in[127:96] + e,  h_in[95:64] + f,   h_in[63:32] + g,    h_in[31:0] + h};
    endfunction

    function automatic logic [255:0] midstate_of(input logic [639:0] h);
        return sha_compress(SHA_IV, h[639:128]);
    endfunction

    function automatic logic [255:0] sha256d_of(input logic [639:0] h);
        logic [255:0] r1;
        r1 = sha_compress(midstate_of(h), {h[127:0], 32'h80000000, 288'h0, 64'h280});
        return sha_compress(SHA_IV, {r1, 32'h80000000, 160'h0, 64'h100});
    endfunction

    // Core model: latches the block on core_enable, answers 67 cycles later.
    logic         withhold = 1'b0;
    logic         pend = 1'b0;
    int           rem = 0;
    int           stab_err = 0;
    logic [511:0] lat_data;
    logic [255:0] lat_hash;

    initial begin
        core_bus.core_hash_done = 1'b0;
        core_bus.core_result    = '0;
    end

    always @(posedge clk) begin
        core_bus.core_hash_done <= 1'b0;
        if (!core_bus.core_n_rst) begin
            pend <= 1'b0;
        end else if (core_bus.core_enable) begin
            pend     <= 1'b1;
            rem      <= 66;
            lat_data <= core_bus.core_data;
            lat_hash <= core_bus.core_hash;
        end else if (pend) begin
            if (core_bus.core_data !== lat_data || core_bus.core_hash !== lat_hash)
                stab_err <= stab_err + 1;
            if (rem == 1) begin
                pend <= 1'b0;
                if (!withhold) begin
                    core_bus.core_hash_done <= 1'b1;
                    core_bus.core_result    <= sha_compress(lat_hash, lat_data);
                end
            end
            rem <= rem - 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    int           job_done_at, job_en_count, job_first_en, job_overlap_total;
    int           job_nrst_low, job_busy_low, job_done_count;
    logic         job_err, job_busy_probe;
    logic [255:0] job_digest, job_first_hash;
    logic [511:0] job_en1_data;

    // Runs one job; extra_at/flush_at/rst_at pulse the input at that cycle offset.
    task automatic applyStimulus(input logic [639:0] hdr, input int max_cyc,
                                 input int extra_at, input int flush_at, input int rst_at);
        int s, t;
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        header = hdr;
        job_done_at = -1; job_en_count = 0; job_first_en = -1;
        job_nrst_low = 0; job_busy_low = 0; job_done_count = 0;
        job_err = 1'b0; job_busy_probe = 1'bx; job_digest = '0;
        job_first_hash = '0; job_en1_data = '0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            t = cyc - s;
            if (core_bus.core_enable) begin
                if (job_en_count == 0) begin
                    job_first_en   = t;
                    job_first_hash = core_bus.core_hash;
                end
                if (job_en_count == 1) job_en1_data = core_bus.core_data;
                job_en_count++;
            end
            if (core_bus.core_enable && core_bus.core_hash_done) job_overlap_total++;
            if (!core_bus.core_n_rst) job_nrst_low++;
            if (rst_at < 0 && job_done_at < 0 && !busy) job_busy_low++;
            if (t == rst_at + 1) job_busy_probe = busy;
            if (done) begin
                job_done_count++;
                if (job_done_at < 0) begin
                    job_done_at = t;
                    job_err     = error;
                    job_digest  = digest;
                end
            end
            start       = (t == extra_at);
            header      = (t == extra_at) ? ~hdr : hdr;
            cache_flush = (t == flush_at);
            rst         = (t == rst_at);
            if (job_done_at >= 0 && rst_at < 0) break;
        end
        start = 1'b0;
        cache_flush = 1'b0;
        rst = 1'b0;
    endtask

    logic [639:0] hdr0, hdr1, hdr3, hdr4;
    logic [255:0] held_digest;

    initial begin
        hdr0 = '0;
        hdr1 = 640'h1;
        hdr3 = {16{40'h0123456789}};
        hdr4 = {20{32'hdeadbeef}};
        job_overlap_total = 0;
        rst = 1'b1; start = 1'b0; header = '0; cache_flush = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_core_n_rst", core_bus.core_n_rst, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_digest", digest, 0);
        checkOutput("rst_core_enable", core_bus.core_enable, 0);
        checkOutput("rst_core_data", core_bus.core_data, 0);
        checkOutput("rst_core_hash", core_bus.core_hash, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_core_n_rst", core_bus.core_n_rst, 1);

        $display("[TB] job 1: zero header, cold cache");
        applyStimulus(hdr0, 400, -1, -1, -1);
        checkOutput("j1_done_at", job_done_at, 205);
        checkOutput("j1_enables", job_en_count, 3);
        checkOutput("j1_first_en", job_first_en, 1);
        checkOutput("j1_b0_hash", job_first_hash, SHA_IV);
        checkOutput("j1_b1_data", job_en1_data, {128'h0, 32'h80000000, 288'h0, 64'h280});
        checkOutput("j1_error", job_err, 0);
        checkOutput("j1_busy_gap", job_busy_low, 0);
        checkOutput("j1_digest", job_digest, sha256d_of(hdr0));
        @(negedge clk);
        checkOutput("j1_done_after", done, 0);
        checkOutput("j1_busy_after", busy, 0);
        checkOutput("j1_digest_held", digest, sha256d_of(hdr0));

        $display("[TB] job 2: same prefix, new nonce");
        applyStimulus(hdr1, 400, -1, -1, -1);
        checkOutput("j2_done_at", job_done_at, 137);
        checkOutput("j2_enables", job_en_count, 2);
        checkOutput("j2_first_en", job_first_en, 1);
        checkOutput("j2_cached_mid", job_first_hash, midstate_of(hdr0));
        checkOutput("j2_digest", job_digest, sha256d_of(hdr1));

        $display("[TB] job 3: flush between jobs");
        @(negedge clk);
        cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        applyStimulus(hdr1, 400, -1, -1, -1);
        checkOutput("j3_done_at", job_done_at, 205);
        checkOutput("j3_enables", job_en_count, 3);

        $display("[TB] job 4: core never answers");
        withhold = 1'b1;
        applyStimulus(hdr1, 400, -1, -1, -1);
        withhold = 1'b0;
        checkOutput("j4_error", job_err, 1);
        checkOutput("j4_enables", job_en_count, 1);
        checkOutput("j4_abort_latency_255_256",
                    (job_done_at - job_first_en == 255) || (job_done_at - job_first_en == 256), 1);
        checkOutput("j4_core_n_rst_low", job_nrst_low, 1);
        checkOutput("j4_digest_kept", job_digest, sha256d_of(hdr1));

        applyStimulus(hdr1, 400, -1, -1, -1);
        checkOutput("j5_miss_after_abort", job_done_at, 205);
        checkOutput("j5_digest", job_digest, sha256d_of(hdr1));

        $display("[TB] job 6: reset mid-job");
        applyStimulus(hdr1, 110, -1, -1, 100);
        checkOutput("j6_no_done", job_done_count, 0);
        checkOutput("j6_busy_after_rst", job_busy_probe, 0);
        checkOutput("j6_core_n_rst_low", job_nrst_low, 1);
        applyStimulus(hdr1, 400, -1, -1, -1);
        checkOutput("j7_miss_after_rst", job_done_at, 205);
        checkOutput("j7_digest", job_digest, sha256d_of(hdr1));

        $display("[TB] job 8: start while busy");
        applyStimulus(hdr3, 400, 50, -1, -1);
        checkOutput("j8_done_at", job_done_at, 205);
        checkOutput("j8_enables", job_en_count, 3);
        checkOutput("j8_digest", job_digest, sha256d_of(hdr3));
        held_digest = job_digest;
        repeat (5) @(negedge clk);
        checkOutput("j8_no_extra_job", busy, 0);
        checkOutput("j8_digest_held", digest, held_digest);

        $display("[TB] job 9: flush coincides with block-0 completion");
        applyStimulus(hdr4, 400, -1, 68, -1);
        checkOutput("j9_done_at", job_done_at, 205);
        checkOutput("j9_digest", job_digest, sha256d_of(hdr4));
        applyStimulus(hdr4, 400, -1, -1, -1);
        checkOutput("j10_flush_won", job_done_at, 205);

        checkOutput("enable_vs_hash_done_overlap", job_overlap_total, 0);
        checkOutput("core_inputs_stable", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
